// File: rtl/alarm_set_ctrl.sv
// alarm_set_ctrl: alarm digit editing FSM with set-mode timeout and alarm ringer
module alarm_set_ctrl #(
  parameter int TIMEOUT_S = 10,
  parameter int RING_S    = 60
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        key_mode,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_clr,
  input  logic        key_en,
  input  logic [15:0] alarm_digits,
  input  logic [15:0] time_digits,
  input  logic        time_sec_zero,
  output logic [3:0]  alarm_add,
  output logic [3:0]  alarm_sub,
  output logic [3:0]  alarm_clear,
  output logic [3:0]  alarm_keep,
  output logic [19:0] alarm_reset,
  output logic        set_mode,
  output logic [3:0]  blink_sel,
  output logic        alarm_en,
  output logic        ring
);
  typedef enum logic [3:0] {
    IDLE, SET_HT, SET_HO, SET_MT, SET_MO, BUSY_HT, BUSY_HO, BUSY_MT, BUSY_MO
  } state_t;
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam int RW = $clog2(RING_S + 1);
  localparam logic [19:0] RST_IDLE = {4{5'b00001}};
  state_t        state_q, state_d, mode_nxt, busy_st, set_st;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          alarm_en_q, alarm_en_d, ring_q, ring_d, set_mode_q, set_mode_d;
  logic [3:0]    add_q, add_d, sub_q, sub_d, clear_q, clear_d, keep_q, keep_d;
  logic [3:0]    blink_q, blink_d, pre_d, dbit, cur, lim, ht_res;
  logic [19:0]   reset_q, reset_d;
  logic [1:0]    dig;
  logic          in_busy, any_key, do_cmd, c_clr, c_up, c_down, wrap_dn, fix_ho;
  logic          t_out, trig, stop;
  // digit index edited in a given state: 3 = hour tens ... 0 = min ones
  function automatic logic [1:0] dig_of(input state_t s);
    return (s == SET_HT || s == BUSY_HT) ? 2'd3 :
           (s == SET_HO || s == BUSY_HO) ? 2'd2 :
           (s == SET_MT || s == BUSY_MT) ? 2'd1 : 2'd0;
  endfunction
  // one-hot preset code selecting a digit maximum
  function automatic logic [4:0] preset_code(input logic [3:0] m);
    return m == 4'd9 ? 5'b00010 : m == 4'd5 ? 5'b00100 : m == 4'd3 ? 5'b01000 : 5'b10000;
  endfunction
  // next-state, command and ringer decode; a ringing alarm swallows every key
  always_comb begin
    in_busy  = state_q inside {BUSY_HT, BUSY_HO, BUSY_MT, BUSY_MO};
    dig      = dig_of(state_q);
    dbit     = 4'b0001 << dig;
    cur      = alarm_digits[4*dig +: 4];
    lim      = dig == 2'd0 ? 4'd9 : dig == 2'd1 ? 4'd5 : dig == 2'd3 ? 4'd2 :
               (alarm_digits[15:12] == 4'd2 ? 4'd3 : 4'd9);
    mode_nxt = state_q == IDLE ? SET_HT : dig == 2'd3 ? SET_HO : dig == 2'd2 ? SET_MT :
               dig == 2'd1 ? SET_MO : IDLE;
    busy_st  = dig == 2'd3 ? BUSY_HT : dig == 2'd2 ? BUSY_HO : dig == 2'd1 ? BUSY_MT : BUSY_MO;
    set_st   = dig == 2'd3 ? SET_HT : dig == 2'd2 ? SET_HO : dig == 2'd1 ? SET_MT : SET_MO;
    any_key  = key_mode | key_up | key_down | key_clr | key_en;
    do_cmd   = !ring_q && state_q inside {SET_HT, SET_HO, SET_MT, SET_MO} && !key_mode &&
               (key_clr | key_up | key_down);
    c_clr    = key_clr;
    c_up     = !key_clr && key_up;
    c_down   = !key_clr && !key_up && key_down;
    wrap_dn  = do_cmd && c_down && cur == 4'd0;
    ht_res   = c_clr ? 4'd0 : c_up ? (cur >= lim ? 4'd0 : cur + 4'd1) :
               (cur == 4'd0 ? lim : cur - 4'd1);
    fix_ho   = do_cmd && dig == 2'd3 && ht_res == 4'd2 && alarm_digits[11:8] > 4'd3;
    add_d    = (do_cmd && c_up && cur < lim) ? dbit : 4'b0;
    clear_d  = (do_cmd && (c_clr || (c_up && cur >= lim))) ? dbit : 4'b0;
    sub_d    = (do_cmd && c_down && cur != 4'd0) ? dbit : 4'b0;
    pre_d    = (wrap_dn ? dbit : 4'b0) | (fix_ho ? 4'b0100 : 4'b0);
    reset_d  = RST_IDLE;
    if (wrap_dn) reset_d[5*dig +: 5] = preset_code(lim);
    if (fix_ho) reset_d[14:10] = 5'b01000;
    keep_d   = ~(add_d | sub_d | clear_d | pre_d);
    t_out    = !ring_q && state_q != IDLE && !key_mode && !do_cmd && tick_1hz &&
               tcnt_q == TW'(TIMEOUT_S - 1);
    state_d  = ring_q ? state_q : key_mode ? mode_nxt : do_cmd ? busy_st : t_out ? IDLE :
               in_busy ? set_st : state_q;
    tcnt_d   = (state_q == IDLE || ring_q || key_mode || do_cmd || t_out) ? '0 :
               tcnt_q + TW'(tick_1hz);
    alarm_en_d = alarm_en_q ^ (!ring_q && state_q == IDLE && !key_mode && key_en);
    trig     = !ring_q && tick_1hz && alarm_en_q && state_q == IDLE && !key_mode &&
               time_sec_zero && time_digits == alarm_digits;
    stop     = any_key || !alarm_en_q || (tick_1hz && rcnt_q == RW'(RING_S - 1));
    ring_d   = ring_q ? !stop : trig;
    rcnt_d   = (ring_q && !stop) ? rcnt_q + RW'(tick_1hz) : '0;
    set_mode_d = state_d != IDLE;
    blink_d  = state_d == IDLE ? 4'b0 : 4'b0001 << dig_of(state_d);
  end
  // state, counters and all outputs are registered; commands are one-cycle pulses
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      rcnt_q     <= '0;
      alarm_en_q <= 1'b0;
      ring_q     <= 1'b0;
      set_mode_q <= 1'b0;
      blink_q    <= 4'b0;
      add_q      <= 4'b0;
      sub_q      <= 4'b0;
      clear_q    <= 4'b0;
      keep_q     <= 4'hf;
      reset_q    <= RST_IDLE;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      rcnt_q     <= rcnt_d;
      alarm_en_q <= alarm_en_d;
      ring_q     <= ring_d;
      set_mode_q <= set_mode_d;
      blink_q    <= blink_d;
      add_q      <= add_d;
      sub_q      <= sub_d;
      clear_q    <= clear_d;
      keep_q     <= keep_d;
      reset_q    <= reset_d;
    end
  end
  assign alarm_add   = add_q;
  assign alarm_sub   = sub_q;
  assign alarm_clear = clear_q;
  assign alarm_keep  = keep_q;
  assign alarm_reset = reset_q;
  assign set_mode    = set_mode_q;
  assign blink_sel   = blink_q;
  assign alarm_en    = alarm_en_q;
  assign ring        = ring_q;
endmodule

// File: tb/tb_alarm_set_ctrl.sv
// tb_alarm_set_ctrl: vector table, corner sequences and randomized model check
module tb_alarm_set_ctrl;
  localparam int TIMEOUT_S = 10;
  localparam int RING_S    = 60;
  localparam logic [19:0] IR = 20'h08421;
  localparam logic [4:0] M = 5'b10000, C = 5'b01000, U = 5'b00100, D = 5'b00010, E = 5'b00001;
  logic sysclk = 0, rst = 0, tick_1hz = 0;
  logic key_mode = 0, key_up = 0, key_down = 0, key_clr = 0, key_en = 0;
  logic [15:0] alarm_digits = 16'h0000, time_digits = 16'hffff;
  logic time_sec_zero = 0;
  logic [3:0] alarm_add, alarm_sub, alarm_clear, alarm_keep, blink_sel;
  logic [19:0] alarm_reset;
  logic set_mode, alarm_en, ring;
  alarm_set_ctrl #(.TIMEOUT_S(TIMEOUT_S), .RING_S(RING_S)) dut (
    .sysclk(sysclk), .rst(rst), .tick_1hz(tick_1hz),
    .key_mode(key_mode), .key_up(key_up), .key_down(key_down), .key_clr(key_clr), .key_en(key_en),
    .alarm_digits(alarm_digits), .time_digits(time_digits), .time_sec_zero(time_sec_zero),
    .alarm_add(alarm_add), .alarm_sub(alarm_sub), .alarm_clear(alarm_clear), .alarm_keep(alarm_keep),
    .alarm_reset(alarm_reset), .set_mode(set_mode), .blink_sel(blink_sel),
    .alarm_en(alarm_en), .ring(ring)
  );
  always #5 sysclk = ~sysclk;
  typedef struct {
    logic [4:0]  keys;
    logic [15:0] ad;
    logic [3:0]  add, sub, clr, keep;
    logic [19:0] rs;
    logic        sm;
    logic [3:0]  blink;
    logic        en;
  } vec_t;
  vec_t tv[$];
  int n_cmp = 0, n_bad = 0;
  int m_pos, m_idle, m_rt;
  bit m_busy, m_en, m_ring;
  logic [3:0] e_add, e_sub, e_clr, e_pre;
  logic [19:0] e_rs;
  function automatic void v(input logic [4:0] k, input logic [15:0] ad, input logic [3:0] a, s, c, kp,
                            input logic [19:0] r, input logic sm, input logic [3:0] b, input logic en);
    tv.push_back('{k, ad, a, s, c, kp, r, sm, b, en});
  endfunction
  function automatic logic [42:0] outs();
    return {alarm_add, alarm_sub, alarm_clear, alarm_keep, alarm_reset, set_mode, blink_sel, alarm_en, ring};
  endfunction
  function automatic logic [42:0] idle_pack(input logic sm, input logic [3:0] b, input logic en, input logic rg);
    return {4'h0, 4'h0, 4'h0, 4'hf, IR, sm, b, en, rg};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic set_keys(input logic [4:0] k);
    {key_mode, key_clr, key_up, key_down, key_en} = k;
  endtask
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    set_keys(0);
    tick_1hz = 0;
    time_sec_zero = 0;
    step();
    step();
    rst = 0;
  endtask
  function automatic logic [15:0] rand_digits();
    return {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
  endfunction
  function automatic void model_reset();
    m_pos = 0; m_idle = 0; m_rt = 0; m_busy = 0; m_en = 0; m_ring = 0;
    e_add = 0; e_sub = 0; e_clr = 0; e_pre = 0; e_rs = IR;
  endfunction
  function automatic void model_step();
    int d, val, lim, nv;
    logic trig;
    e_add = 0; e_sub = 0; e_clr = 0; e_pre = 0; e_rs = IR;
    if (m_ring) begin
      if (key_mode || key_clr || key_up || key_down || key_en || !m_en) m_ring = 0;
      else if (tick_1hz) begin
        m_rt++;
        if (m_rt == RING_S) m_ring = 0;
      end
      return;
    end
    trig = tick_1hz && m_en && m_pos == 0 && !key_mode && time_sec_zero && time_digits == alarm_digits;
    if (key_mode) begin
      m_pos = (m_pos + 1) % 5; m_busy = 0; m_idle = 0;
    end else if (m_pos != 0 && !m_busy && (key_clr || key_up || key_down)) begin
      d = 4 - m_pos;
      val = int'(alarm_digits[4*d +: 4]);
      lim = d == 0 ? 9 : d == 1 ? 5 : d == 3 ? 2 : (alarm_digits[15:12] == 4'd2 ? 3 : 9);
      if (key_clr) begin e_clr[d] = 1; nv = 0; end
      else if (key_up) begin
        if (val < lim) begin e_add[d] = 1; nv = val + 1; end
        else begin e_clr[d] = 1; nv = 0; end
      end else if (val > 0) begin e_sub[d] = 1; nv = val - 1; end
      else begin
        e_pre[d] = 1; nv = lim;
        e_rs[5*d +: 5] = 5'b00001 << (lim == 9 ? 1 : lim == 5 ? 2 : lim == 3 ? 3 : 4);
      end
      if (d == 3 && nv == 2 && alarm_digits[11:8] > 4'd3) begin e_pre[2] = 1; e_rs[14:10] = 5'b01000; end
      m_busy = 1; m_idle = 0;
    end else if (m_pos != 0 && tick_1hz && m_idle + 1 == TIMEOUT_S) begin
      m_pos = 0; m_busy = 0; m_idle = 0;
    end else begin
      m_busy = 0;
      if (m_pos != 0 && tick_1hz) m_idle++;
      if (m_pos == 0 && key_en) m_en = !m_en;
    end
    if (trig) begin m_ring = 1; m_rt = 0; end
  endfunction
  function automatic logic [42:0] model_outs();
    return {e_add, e_sub, e_clr, ~(e_add | e_sub | e_clr | e_pre), e_rs, 1'(m_pos != 0),
            m_pos == 0 ? 4'b0 : 4'(1 << (4 - m_pos)), 1'(m_en), 1'(m_ring)};
  endfunction
  initial begin
    v(0,     16'h1730, 0, 0, 0, 4'hf, IR,       0, 0, 0);
    v(M | U, 16'h1730, 0, 0, 0, 4'hf, IR,       1, 8, 0);
    v(U,     16'h1730, 8, 0, 0, 4'h3, 20'h0A021, 1, 8, 0);
    v(U,     16'h2330, 0, 0, 0, 4'hf, IR,       1, 8, 0);
    v(U,     16'h2330, 0, 0, 8, 4'h7, IR,       1, 8, 0);
    v(0,     16'h2030, 0, 0, 0, 4'hf, IR,       1, 8, 0);
    v(D,     16'h0330, 0, 0, 0, 4'h7, 20'h80421, 1, 8, 0);
    v(M,     16'h2030, 0, 0, 0, 4'hf, IR,       1, 4, 0);
    v(D,     16'h2030, 0, 0, 0, 4'hb, 20'h0A021, 1, 4, 0);
    v(C,     16'h2330, 0, 0, 0, 4'hf, IR,       1, 4, 0);
    v(C,     16'h2330, 0, 0, 4, 4'hb, IR,       1, 4, 0);
    v(M,     16'h2330, 0, 0, 0, 4'hf, IR,       1, 2, 0);
    v(D,     16'h2000, 0, 0, 0, 4'hd, 20'h08481, 1, 2, 0);
    v(U,     16'h2000, 0, 0, 0, 4'hf, IR,       1, 2, 0);
    v(U,     16'h2050, 0, 0, 2, 4'hd, IR,       1, 2, 0);
    v(M,     16'h2050, 0, 0, 0, 4'hf, IR,       1, 1, 0);
    v(U,     16'h2009, 0, 0, 1, 4'he, IR,       1, 1, 0);
    v(0,     16'h2009, 0, 0, 0, 4'hf, IR,       1, 1, 0);
    v(U,     16'h2005, 1, 0, 0, 4'he, IR,       1, 1, 0);
    v(E,     16'h2006, 0, 0, 0, 4'hf, IR,       1, 1, 0);
    v(M,     16'h2006, 0, 0, 0, 4'hf, IR,       0, 0, 0);
    v(U,     16'h2006, 0, 0, 0, 4'hf, IR,       0, 0, 0);
    v(E,     16'h2006, 0, 0, 0, 4'hf, IR,       0, 0, 1);
    v(C | E, 16'h2006, 0, 0, 0, 4'hf, IR,       0, 0, 0);
    v(E,     16'h2006, 0, 0, 0, 4'hf, IR,       0, 0, 1);
    v(M,     16'h1730, 0, 0, 0, 4'hf, IR,       1, 8, 1);
    v(C|U|D, 16'h1730, 0, 0, 8, 4'h7, IR,       1, 8, 1);
    v(0,     16'h1730, 0, 0, 0, 4'hf, IR,       1, 8, 1);
    v(U | D, 16'h1730, 8, 0, 0, 4'h3, 20'h0A021, 1, 8, 1);
    v(0,     16'h1730, 0, 0, 0, 4'hf, IR,       1, 8, 1);
    v(D,     16'h1730, 0, 8, 0, 4'h7, IR,       1, 8, 1);
    do_reset();
    chk("reset_state", outs(), idle_pack(0, 0, 0, 0));
    foreach (tv[i]) begin
      set_keys(tv[i].keys);
      alarm_digits = tv[i].ad;
      step();
      chk($sformatf("vec%0d", i), outs(), {tv[i].add, tv[i].sub, tv[i].clr, tv[i].keep, tv[i].rs,
                                           tv[i].sm, tv[i].blink, tv[i].en, 1'b0});
    end
    set_keys(0);
    do_reset();
    set_keys(M); step(); set_keys(M); step(); set_keys(0);
    chk("timeout_enter_ho", {set_mode, blink_sel}, {1'b1, 4'b0100});
    for (int i = 1; i <= TIMEOUT_S; i++) begin
      tick_1hz = 1; step(); tick_1hz = 0;
      if (i < TIMEOUT_S) chk($sformatf("timeout_hold%0d", i), {set_mode, blink_sel}, {1'b1, 4'b0100});
      else chk("timeout_exit", outs(), idle_pack(0, 0, 0, 0));
      step();
    end
    do_reset();
    set_keys(E); step(); set_keys(0);
    chk("ring_en_on", alarm_en, 1'b1);
    alarm_digits = 16'h0730; time_digits = 16'h0730; time_sec_zero = 1;
    tick_1hz = 1; step(); tick_1hz = 0; time_sec_zero = 0;
    chk("ring_start", ring, 1'b1);
    for (int k = 1; k <= RING_S; k++) begin
      tick_1hz = 1; step(); tick_1hz = 0;
      chk($sformatf("ring_tick%0d", k), ring, 1'(k < RING_S));
      step();
    end
    time_sec_zero = 1; tick_1hz = 1; step(); tick_1hz = 0; time_sec_zero = 0;
    chk("ring_restart", ring, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick_1hz = 1; step(); tick_1hz = 0; step();
    end
    chk("ring_before_key", ring, 1'b1);
    tick_1hz = 1; set_keys(U); step(); tick_1hz = 0; set_keys(0);
    chk("ring_key_stop", outs(), idle_pack(0, 0, 1, 0));
    step();
    chk("ring_key_after", outs(), idle_pack(0, 0, 1, 0));
    time_digits = 16'hffff;
    do_reset();
    set_keys(M); step();
    alarm_digits = 16'h1730; set_keys(U); rst = 1; step(); set_keys(0); rst = 0;
    chk("reset_mid_edit", outs(), idle_pack(0, 0, 0, 0));
    step();
    chk("reset_release", outs(), idle_pack(0, 0, 0, 0));
    do_reset();
    model_reset();
    for (int c = 0; c < 6000; c++) begin
      logic [4:0] k;
      int p;
      p = ((c / 500) % 2) ? 59 : 7;
      for (int b = 0; b < 5; b++) k[b] = ($urandom_range(0, p) == 0);
      rst = ($urandom_range(0, 299) == 0);
      set_keys(k);
      tick_1hz = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) alarm_digits = rand_digits();
      time_digits = $urandom_range(0, 1) ? alarm_digits : rand_digits();
      time_sec_zero = ($urandom_range(0, 2) == 0);
      if (rst) model_reset();
      else model_step();
      step();
      chk($sformatf("random%0d", c), outs(), model_outs());
    end
    rst = 0;
    set_keys(0);
    tick_1hz = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
